// File: rtl/p2p_mult_scheduler.sv
// rtl/p2p_mult_scheduler.sv - round-robin scheduler for the element-wise multiply engine
// Loads SIZE operands per job, then streams a[i]*coef[i] with backpressure.
module p2p_mult_scheduler #(
  parameter int SIZE = 16,
  parameter int DW   = 8,
  parameter int AW   = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [1:0]      req_i,
  output logic [1:0]      gnt_o,
  output logic            busy_o,
  input  logic            in_valid_i,
  input  logic [DW-1:0]   in_data_i,
  output logic            in_ready_o,
  input  logic            coef_we_i,
  input  logic [AW-1:0]   coef_addr_i,
  input  logic [DW-1:0]   coef_data_i,
  output logic            cfg_err_o,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [2*DW-1:0] out_data_o,
  output logic [AW-1:0]   out_idx_o,
  output logic            done_o,
  output logic            abort_o
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMPUTE, S_DONE} state_e;

  state_e          state_q;
  logic [AW:0]     cnt_q;
  logic            owner_q, last_owner_q;
  logic [1:0]      gnt_q;
  logic            busy_q, in_ready_q, out_valid_q, done_q, abort_q, cfg_err_q;
  logic [2*DW-1:0] out_data_q;
  logic [AW-1:0]   out_idx_q;
  logic [DW-1:0]   coef_q [SIZE];
  logic [DW-1:0]   buf_q  [SIZE];

  logic            owner_d;
  logic [AW-1:0]   cidx_d;
  logic [2*DW-1:0] prod_d;
  logic            issue_d, out_hs_d, in_hs_d;

  // With both requesters pending, the one not served last wins.
  always_comb begin
    owner_d = req_i[1];
    if (req_i == 2'b11) owner_d = ~last_owner_q;
  end

  // cnt_q[AW] set in COMPUTE means all SIZE products have been issued.
  assign cidx_d   = cnt_q[AW-1:0];
  assign prod_d   = {{DW{1'b0}}, buf_q[cidx_d]} * {{DW{1'b0}}, coef_q[cidx_d]};
  assign issue_d  = (!out_valid_q || out_ready_i) && !cnt_q[AW];
  assign out_hs_d = out_valid_q && out_ready_i;
  assign in_hs_d  = in_valid_i && in_ready_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      gnt_q        <= 2'b00;
      busy_q       <= 1'b0;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_idx_q    <= '0;
      done_q       <= 1'b0;
      abort_q      <= 1'b0;
      cfg_err_q    <= 1'b0;
      for (int i = 0; i < SIZE; i++) begin
        coef_q[i] <= '0;
        buf_q[i]  <= '0;
      end
    end else begin
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
      cfg_err_q <= 1'b0;

      if (coef_we_i) begin
        if (state_q == S_IDLE) coef_q[coef_addr_i] <= coef_data_i;
        else                   cfg_err_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (req_i != 2'b00) begin
            state_q    <= S_LOAD;
            owner_q    <= owner_d;
            gnt_q      <= owner_d ? 2'b10 : 2'b01;
            busy_q     <= 1'b1;
            in_ready_q <= 1'b1;
            cnt_q      <= '0;
          end
        end
        S_LOAD: begin
          if (!req_i[owner_q]) begin
            abort_q      <= 1'b1;
            state_q      <= S_IDLE;
            gnt_q        <= 2'b00;
            busy_q       <= 1'b0;
            in_ready_q   <= 1'b0;
            cnt_q        <= '0;
            last_owner_q <= owner_q;
          end else if (in_hs_d) begin
            buf_q[cidx_d] <= in_data_i;
            if (cnt_q == (AW+1)'(SIZE-1)) begin
              state_q    <= S_COMPUTE;
              in_ready_q <= 1'b0;
              cnt_q      <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        S_COMPUTE: begin
          if (issue_d) begin
            out_valid_q <= 1'b1;
            out_data_q  <= prod_d;
            out_idx_q   <= cidx_d;
            cnt_q       <= cnt_q + 1'b1;
          end else if (out_hs_d) begin
            out_valid_q <= 1'b0;
          end
          if (out_hs_d && out_idx_q == AW'(SIZE-1)) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q      <= S_IDLE;
          gnt_q        <= 2'b00;
          busy_q       <= 1'b0;
          cnt_q        <= '0;
          last_owner_q <= owner_q;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign gnt_o       = gnt_q;
  assign busy_o      = busy_q;
  assign in_ready_o  = in_ready_q;
  assign cfg_err_o   = cfg_err_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_idx_o   = out_idx_q;
  assign done_o      = done_q;
  assign abort_o     = abort_q;

endmodule

// File: tb/tb_p2p_mult_scheduler.sv
// tb/tb_p2p_mult_scheduler.sv - directed table-driven bench for p2p_mult_scheduler
module tb_p2p_mult_scheduler;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [1:0]  req_i;
  logic [1:0]  gnt_o;
  logic        busy_o, in_valid_i, in_ready_o, coef_we_i, cfg_err_o;
  logic [7:0]  in_data_i, coef_data_i;
  logic [3:0]  coef_addr_i, out_idx_o;
  logic        out_valid_o, out_ready_i, done_o, abort_o;
  logic [15:0] out_data_o;

  p2p_mult_scheduler #(.SIZE(16), .DW(8), .AW(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt_o), .busy_o(busy_o),
    .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_ready_o(in_ready_o),
    .coef_we_i(coef_we_i), .coef_addr_i(coef_addr_i), .coef_data_i(coef_data_i),
    .cfg_err_o(cfg_err_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_data_o(out_data_o), .out_idx_o(out_idx_o), .done_o(done_o), .abort_o(abort_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  c;
    logic [15:0] p;
  } vec_t;

  vec_t        tbl [16];
  logic [7:0]  ops [16];
  logic [15:0] expv [16];
  bit          pat [4];
  int          npass = 0;
  int          ntotal = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"}, gnt_o, 0);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_in_ready"}, in_ready_o, 0);
    check({tag, "_out_valid"}, out_valid_o, 0);
    check({tag, "_out_data"}, out_data_o, 0);
    check({tag, "_out_idx"}, out_idx_o, 0);
    check({tag, "_done"}, done_o, 0);
    check({tag, "_abort"}, abort_o, 0);
    check({tag, "_cfg_err"}, cfg_err_o, 0);
  endtask

  task automatic write_coef(input logic [3:0] a, input logic [7:0] d);
    coef_we_i = 1'b1; coef_addr_i = a; coef_data_i = d;
    @(negedge clk_i);
    coef_we_i = 1'b0;
  endtask

  task automatic use_table();
    for (int i = 0; i < 16; i++) begin
      write_coef(4'(i), tbl[i].c);
      ops[i]  = tbl[i].a;
      expv[i] = tbl[i].p;
    end
  endtask

  task automatic wait_grant(input logic [1:0] eg);
    int t = 0;
    while (gnt_o == 2'b00 && t < 8) begin @(negedge clk_i); t++; end
    check("grant", gnt_o, eg);
    check("busy_on_grant", busy_o, 1);
    check("in_ready_on_grant", in_ready_o, 1);
  endtask

  task automatic load_ops(input int n);
    int k = 0;
    int t = 0;
    while (k < n && t < 100) begin
      check("no_out_in_load", out_valid_o, 0);
      if (in_ready_o) begin in_valid_i = 1'b1; in_data_i = ops[k]; k++; end
      else in_valid_i = 1'b0;
      @(negedge clk_i); t++;
    end
    in_valid_i = 1'b0;
    check("load_count", k, n);
  endtask

  task automatic do_job(input logic [1:0] rq, input logic [1:0] eg, input int mode, input bit inject);
    int n = 0;
    int cyc = 0;
    bit fin = 0;
    req_i = rq;
    wait_grant(eg);
    load_ops(16);
    while (!fin && cyc < 200) begin
      out_ready_i = (mode == 0) ? 1'b1 : pat[cyc % 4];
      if (inject && cyc == 0) begin coef_we_i = 1'b1; coef_addr_i = 4'd3; coef_data_i = 8'h55; end
      if (inject && cyc == 1) begin check("cfg_err_pulse", cfg_err_o, 1); coef_we_i = 1'b0; end
      if (done_o) begin
        fin = 1;
        check("products_at_done", n, 16);
      end else begin
        check("gnt_hold", gnt_o, eg);
        if (out_valid_o) begin
          if (n > 15) check("extra_product", n, 15);
          else begin
            check("out_data", out_data_o, expv[n]);
            check("out_idx", out_idx_o, n);
          end
          if (out_ready_i) n++;
        end
      end
      if (!fin) begin @(negedge clk_i); cyc++; end
    end
    check("done_seen", fin, 1);
    out_ready_i = 1'b1;
    @(negedge clk_i);
    check("done_single", done_o, 0);
    check("gnt_released", gnt_o, 0);
    check("busy_released", busy_o, 0);
    check("out_valid_cleared", out_valid_o, 0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      tbl[i].a = 8'(i + 2);
      tbl[i].c = 8'(i + 1);
      tbl[i].p = 16'((i + 2) * (i + 1));
    end
    pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1;
    rst_ni = 1'b1; req_i = 2'b00; in_valid_i = 1'b0; in_data_i = '0;
    coef_we_i = 1'b0; coef_addr_i = '0; coef_data_i = '0; out_ready_i = 1'b1;
    #3 rst_ni = 1'b0;
    #1 check_all_zero("reset");
    @(negedge clk_i) rst_ni = 1'b1;
    @(negedge clk_i);

    // Basic job, then all-ones corner.
    use_table();
    do_job(2'b01, 2'b01, 0, 0);
    req_i = 2'b00;
    for (int i = 0; i < 16; i++) begin
      write_coef(4'(i), 8'hFF); ops[i] = 8'hFF; expv[i] = 16'hFE01;
    end
    do_job(2'b01, 2'b01, 0, 0);
    req_i = 2'b00;

    // Round-robin from reset with both requesters held.
    #2 rst_ni = 1'b0;
    @(negedge clk_i) rst_ni = 1'b1;
    @(negedge clk_i);
    use_table();
    do_job(2'b11, 2'b01, 0, 0);
    do_job(2'b11, 2'b10, 0, 0);
    do_job(2'b11, 2'b01, 0, 0);
    req_i = 2'b00;

    // Stall pattern 1,0,0,1 and a dropped coefficient write in COMPUTE.
    do_job(2'b01, 2'b01, 1, 0);
    req_i = 2'b00;
    do_job(2'b01, 2'b01, 0, 1);
    req_i = 2'b00;

    // Abort after 5 operands.
    for (int i = 0; i < 16; i++) ops[i] = 8'hAA;
    req_i = 2'b01;
    wait_grant(2'b01);
    load_ops(5);
    req_i = 2'b00;
    @(negedge clk_i);
    check("abort_pulse", abort_o, 1);
    check("abort_gnt", gnt_o, 0);
    check("abort_busy", busy_o, 0);
    check("abort_in_ready", in_ready_o, 0);
    check("abort_no_out", out_valid_o, 0);
    @(negedge clk_i);
    check("abort_single", abort_o, 0);
    for (int i = 0; i < 16; i++) begin ops[i] = tbl[i].a; expv[i] = tbl[i].p; end
    do_job(2'b01, 2'b01, 0, 0);
    req_i = 2'b00;

    // Reset in the middle of COMPUTE wipes coefficients.
    begin
      int t = 0;
      req_i = 2'b01;
      wait_grant(2'b01);
      load_ops(16);
      out_ready_i = 1'b1;
      while (!(out_valid_o && out_idx_o >= 4) && t < 40) begin @(negedge clk_i); t++; end
      check("reach_mid_compute", t < 40, 1);
      #2 rst_ni = 1'b0;
      #1 check_all_zero("mid_reset");
      req_i = 2'b00;
      @(negedge clk_i) rst_ni = 1'b1;
      @(negedge clk_i);
    end
    for (int i = 0; i < 16; i++) begin ops[i] = tbl[i].a; expv[i] = 16'h0000; end
    do_job(2'b01, 2'b01, 0, 0);
    req_i = 2'b00;
    use_table();
    do_job(2'b10, 2'b10, 0, 0);
    req_i = 2'b00;

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
